lcd_bus_decoder: RTL
====================

# lcd_bus_decoder

Upstream front end of the LCD-to-DVI path. It receives the MCU-side 8080-style 8-bit LCD write bus and synchronises it into `i_clk`. It decodes each write strobe into a command byte, a parameter byte, or half of an RGB565 pixel. Results go out as single-cycle latch pulses to the framebuffer's command, parameter and pixel inputs.

## Interface

Parameters:

- `RAMWR_CMD`, default 8'h2C: memory-write command; enters pixel mode.
- `RAMWRC_CMD`, default 8'h3C: memory-write-continue command; enters pixel mode.

Ports:

- `i_clk` in 1: system clock. This is the only clock in the block.
- `i_rst_n` in 1: reset. Asynchronous assert, active-low.
- `i_lcd_cs_n` in 1: bus chip select, active-low. Asynchronous to `i_clk`.
- `i_lcd_rs` in 1: register select. 0 = command, 1 = data. Asynchronous.
- `i_lcd_wr_n` in 1: write strobe. Data is taken on its rising edge. Asynchronous.
- `i_lcd_data` in 8: bus data. Asynchronous.
- `o_command` out 8: last command byte.
- `o_command_latch` out 1: one-cycle pulse; `o_command` is valid in this cycle.
- `o_param` out 8: last parameter byte.
- `o_param_latch` out 1: one-cycle pulse; `o_param` is valid in this cycle.
- `o_rgb565` out 16: last assembled pixel, `{first byte, second byte}`.
- `o_rgb565_latch` out 1: one-cycle pulse; `o_rgb565` is valid in this cycle.
- `o_pixel_mode` out 1: high while data writes are decoded as pixels.

## Operation

- **Input capture.**
  - All four bus inputs pass through an identical capture pipeline. CS, RS and data are therefore always aligned with the WR sample.
  - A write event is a captured `wr_n` transition 0→1 while the captured `cs_n` is 0 in the same sample.
  - RS and data are taken from that same aligned sample.
- **Command write (rs=0).**
  - `o_command` ← data and `o_command_latch` pulses.
  - `o_pixel_mode` ← 1 if data equals `RAMWR_CMD` or `RAMWRC_CMD`, otherwise ← 0.
  - The byte phase resets to HI.
- **Data write (rs=1) with `o_pixel_mode`=0.**
  - `o_param` ← data and `o_param_latch` pulses.
- **Data write (rs=1) with `o_pixel_mode`=1.** Two-state byte FSM:
  - HI: store data in the high-byte register, then go to LO. No output pulse.
  - LO: `o_rgb565` ← `{hi_reg, data}`, `o_rgb565_latch` pulses, then go to HI.
- **CS deassert.** A captured `cs_n` 0→1 edge resets the byte phase to HI.
  - Any pending high byte is discarded.
  - `o_pixel_mode` is retained, so a pixel stream may continue after CS toggles.
- **Non-events.** WR edges while `cs_n`=1 are ignored entirely.
- **Exclusivity.** At most one latch output is high in any cycle.
- **Data outputs.** Data outputs hold their value between pulses.

## Timing

- **Reset values.** All outputs are 0. FSM is in HI, `o_pixel_mode`=0, and capture registers are 1 for `cs_n`/`wr_n` and 0 otherwise.
- **Latency with `LCD_BUS_SYNC_EN`.**
  - Let N be the first `i_clk` edge that samples `i_lcd_wr_n` high.
  - The latch pulse is high in the cycle after edge N+2.
- **Latency without `LCD_BUS_SYNC_EN`.** The pulse is high in the cycle after edge N+1.
- **Bus timing requirement.** `i_lcd_wr_n` low and high phases each last ≥3 `i_clk` periods with sync, ≥2 without.
  - Data, RS and CS must be stable for the same window around the WR rising edge.
  - Violations may drop writes. They must never produce two pulses for one strobe.
- **Simultaneous events.** If a CS 0→1 edge and a write event are both detected in the same sample, the write is processed first, then the phase reset applies.
  - Net result: an LO write emits its pixel and the phase ends at HI.
- **Reset during a write.** Asynchronous reset clears everything immediately. A half-assembled pixel is lost.

## Configuration

- **`LCD_BUS_SYNC_EN` defined.**
  - Each bus input gets a two-flop synchroniser, followed by one history flop for edge detection.
  - Use this when the MCU bus is asynchronous to `i_clk`.
- **`LCD_BUS_SYNC_EN` undefined.**
  - Inputs are registered once, plus the history flop. Latency is one cycle less.
  - Use this only when the bus is generated synchronously to `i_clk`, for example a bench or an internal pattern source.

## Test plan

- **Reset.** Assert `i_rst_n`=0 mid-stream → all outputs 0, `o_pixel_mode`=0. After release, the first data write produces an `o_param_latch` pulse.
- **Command and parameter.** Command 8'h36 then data 8'h48 → `o_command_latch` with `o_command`=8'h36, then `o_param_latch` with `o_param`=8'h48, `o_pixel_mode`=0. Exactly one pulse per strobe at the specified latency.
- **Pixel assembly.** Command 8'h2C, then data 8'hF8, 8'h00, 8'h07, 8'hE0 → two `o_rgb565_latch` pulses with 16'hF800 then 16'h07E0, and no `o_param_latch`.
- **CS abort.** After 8'h2C, send data 8'hAB, raise CS, lower CS, then send 8'h12 and 8'h34 → a single pixel 16'h1234. The 8'hAB is discarded and `o_pixel_mode` stays 1.
- **Mode exit and gated strobe.** After pixel mode, command 8'h2A then data 8'h00 → `o_param_latch` with 8'h00 and `o_pixel_mode`=0. A WR pulse with CS high produces no pulse.
- **Simultaneous edges.** Odd byte count 8'h3C, 8'h11, 8'h22, 8'h33, then CS high → pixel 16'h1122 only. A following 8'h44, 8'h55 yields 16'h4455.

Source files
------------

// File: rtl/lcd_bus_decoder.sv
// 8080-style LCD write bus capture and decode into command, parameter and RGB565 pixel pulses.
// Define LCD_BUS_SYNC_EN to add a two-flop synchroniser when the bus is asynchronous to i_clk.
module lcd_bus_decoder #(
    parameter logic [7:0] RAMWR_CMD  = 8'h2C,
    parameter logic [7:0] RAMWRC_CMD = 8'h3C
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lcd_cs_n,
    input  logic        i_lcd_rs,
    input  logic        i_lcd_wr_n,
    input  logic [7:0]  i_lcd_data,
    output logic [7:0]  o_command,
    output logic        o_command_latch,
    output logic [7:0]  o_param,
    output logic        o_param_latch,
    output logic [15:0] o_rgb565,
    output logic        o_rgb565_latch,
    output logic        o_pixel_mode
);

    typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} phase_t;

    typedef struct packed {
        logic       cs_n;
        logic       wr_n;
        logic       rs;
        logic [7:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, rs: 1'b0, data: 8'h00};

    bus_t   bus_in;
    bus_t   bus_cur;
    logic   prev_cs_n;
    logic   prev_wr_n;
    logic   wr_event;
    logic   cs_rise;
    logic   pixel_mode;
    logic   cmd_fire;
    logic   param_fire;
    logic   hi_store;
    logic   pix_fire;
    logic [7:0] hi_reg;
    phase_t phase;
    phase_t phase_next;

    assign bus_in = {i_lcd_cs_n, i_lcd_wr_n, i_lcd_rs, i_lcd_data};

`ifdef LCD_BUS_SYNC_EN
    bus_t sync_q1;
    bus_t sync_q2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q1 <= BUS_IDLE;
            sync_q2 <= BUS_IDLE;
        end else begin
            sync_q1 <= bus_in;
            sync_q2 <= sync_q1;
        end
    end

    assign bus_cur = sync_q2;
`else
    bus_t reg_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reg_q <= BUS_IDLE;
        end else begin
            reg_q <= bus_in;
        end
    end

    assign bus_cur = reg_q;
`endif

    // History flops: only the strobes need edge detection; RS and data are read from bus_cur.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_cs_n <= 1'b1;
            prev_wr_n <= 1'b1;
        end else begin
            prev_cs_n <= bus_cur.cs_n;
            prev_wr_n <= bus_cur.wr_n;
        end
    end

    assign wr_event = !prev_wr_n && bus_cur.wr_n && !bus_cur.cs_n;
    assign cs_rise  = !prev_cs_n && bus_cur.cs_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase <= PH_HI;
        end else begin
            phase <= phase_next;
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        phase_next = phase;
        if (wr_event) begin
            if (!bus_cur.rs) begin
                phase_next = PH_HI;
            end else if (pixel_mode) begin
                phase_next = (phase == PH_HI) ? PH_LO : PH_HI;
            end
        end
        // A CS release in the same sample overrides the write's phase step.
        if (cs_rise) begin
            phase_next = PH_HI;
        end
    end

    always_comb begin
        cmd_fire   = 1'b0;
        param_fire = 1'b0;
        hi_store   = 1'b0;
        pix_fire   = 1'b0;
        if (wr_event) begin
            if (!bus_cur.rs) begin
                cmd_fire = 1'b1;
            end else if (!pixel_mode) begin
                param_fire = 1'b1;
            end else if (phase == PH_HI) begin
                hi_store = 1'b1;
            end else begin
                pix_fire = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_command       <= 8'h00;
            o_command_latch <= 1'b0;
            o_param         <= 8'h00;
            o_param_latch   <= 1'b0;
            o_rgb565        <= 16'h0000;
            o_rgb565_latch  <= 1'b0;
            pixel_mode      <= 1'b0;
            hi_reg          <= 8'h00;
        end else begin
            o_command_latch <= cmd_fire;
            o_param_latch   <= param_fire;
            o_rgb565_latch  <= pix_fire;
            if (cmd_fire) begin
                o_command  <= bus_cur.data;
                pixel_mode <= (bus_cur.data == RAMWR_CMD) || (bus_cur.data == RAMWRC_CMD);
            end
            if (param_fire) begin
                o_param <= bus_cur.data;
            end
            if (hi_store) begin
                hi_reg <= bus_cur.data;
            end
            if (pix_fire) begin
                o_rgb565 <= {hi_reg, bus_cur.data};
            end
        end
    end

    assign o_pixel_mode = pixel_mode;

endmodule
